// File: rtl/rotating_square_scanner.sv
// Rotating-square generator for a multiplexed common-anode seven-segment display.
// Define ROTSQ_BOUNCE_EN to make the square ping-pong instead of wrapping (dir_i is then ignored).
module rotating_square_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 2**18,
  parameter int STEP_DIV    = 2**24
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  dir_i,
  output logic [NUM_DIGITS-1:0] an_o,
  output logic [6:0]            sseg_o
);

  localparam int NUM_POS = 2 * NUM_DIGITS;
  localparam int RCNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SCNT_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int POS_W   = $clog2(NUM_POS);

  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REFRESH_DIV - 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(STEP_DIV - 1);
  localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUM_DIGITS - 1);
  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(NUM_POS - 1);

  localparam logic [6:0] SEG_TOP   = 7'b0011100;
  localparam logic [6:0] SEG_BOT   = 7'b0100011;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic [RCNT_W-1:0] rcnt_q;
  logic [SCNT_W-1:0] scnt_q;
  logic [DIG_W-1:0]  digit_q;
  logic [POS_W-1:0]  pos_q;
  logic [POS_W-1:0]  pos_d;
  logic              refresh_tick;
  logic              step_tick;
  logic [NUM_DIGITS-1:0] an_d;
  logic [6:0]            sseg_d;

`ifdef ROTSQ_BOUNCE_EN
  logic fwd_q;
  logic fwd_d;
  logic unused_dir;
  assign unused_dir = dir_i;
`endif

  // Top row runs left-to-right as p rises, bottom row right-to-left.
  function automatic logic [6:0] seg_for(input logic [DIG_W-1:0] d, input logic [POS_W-1:0] p);
    int di;
    int pi;
    logic [6:0] seg;
    di  = int'(d);
    pi  = int'(p);
    seg = SEG_BLANK;
    if (pi < NUM_DIGITS) begin
      if (di == NUM_DIGITS - 1 - pi) seg = SEG_TOP;
    end else begin
      if (di == pi - NUM_DIGITS) seg = SEG_BOT;
    end
    return seg;
  endfunction

  assign refresh_tick = (rcnt_q == RCNT_LAST);
  assign step_tick    = en_i && (scnt_q == SCNT_LAST);

  always_comb begin
    pos_d = pos_q;
`ifdef ROTSQ_BOUNCE_EN
    fwd_d = fwd_q;
    if (step_tick) begin
      if (fwd_q) begin
        if (pos_q == POS_LAST) begin
          fwd_d = 1'b0;
          pos_d = POS_LAST - POS_W'(1);
        end else begin
          pos_d = pos_q + POS_W'(1);
        end
      end else begin
        if (pos_q == '0) begin
          fwd_d = 1'b1;
          pos_d = POS_W'(1);
        end else begin
          pos_d = pos_q - POS_W'(1);
        end
      end
    end
`else
    if (step_tick) begin
      if (dir_i) pos_d = (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);
      else       pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
    end
`endif
  end

  always_comb begin
    an_d   = ~(NUM_DIGITS'(1) << digit_q);
    sseg_d = seg_for(digit_q, pos_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rcnt_q  <= '0;
      scnt_q  <= '0;
      digit_q <= '0;
      pos_q   <= '0;
      an_o    <= '1;
      sseg_o  <= SEG_BLANK;
`ifdef ROTSQ_BOUNCE_EN
      fwd_q   <= 1'b1;
`endif
    end else begin
      rcnt_q <= refresh_tick ? '0 : rcnt_q + RCNT_W'(1);
      if (refresh_tick) digit_q <= (digit_q == DIG_LAST) ? '0 : digit_q + DIG_W'(1);
      if (en_i) scnt_q <= step_tick ? '0 : scnt_q + SCNT_W'(1);
      pos_q  <= pos_d;
`ifdef ROTSQ_BOUNCE_EN
      fwd_q  <= fwd_d;
`endif
      // Outputs reflect the digit/position state of the previous cycle.
      an_o   <= an_d;
      sseg_o <= sseg_d;
    end
  end

endmodule
